// File: rtl/gpu_cv_pkg.sv
// Shared definitions for the VRAM->VRAM copy (CV) engine: VRAM geometry,
// copy-writer state encoding and per-pixel write-mask constants.
package gpu_cv_pkg;

  // VRAM is 1024 x 512 pixels, 16 bits per pixel, written as 32-bit pairs
  localparam int VRAM_X_W = 10;
  localparam int VRAM_Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } cv_state_t;

  // Pair write enables {odd pixel, even pixel}
  localparam logic [1:0] MSK_LO   = 2'b01;
  localparam logic [1:0] MSK_HI   = 2'b10;
  localparam logic [1:0] MSK_BOTH = 2'b11;

  // Mask bit (bit15) of both pixels in a pair
  localparam logic [31:0] FORCE_BITS = 32'h8000_8000;

endpackage

// File: rtl/cv_line_mask.sv
// Per-pair write enables for one destination line. An odd left edge drops
// the even pixel of the first pair; an even right edge drops the odd pixel
// of the last pair. A line that fits in one pair gets both restrictions.
module cv_line_mask
  import gpu_cv_pkg::*;
(
  input  logic       xs_lo,
  input  logic       xe_lo,
  input  logic       is_first,
  input  logic       is_last,
  output logic [1:0] mask
);

  logic [1:0] first_mask;
  logic [1:0] last_mask;

  // combine left- and right-edge trimming for the pair being popped
  always_comb begin
    first_mask = xs_lo ? MSK_HI : MSK_BOTH;
    last_mask  = xe_lo ? MSK_BOTH : MSK_LO;
    mask       = MSK_BOTH;
    if (is_first) mask = mask & first_mask;
    if (is_last)  mask = mask & last_mask;
  end

endmodule

// File: rtl/cv_copy_writer.sv
// Write side of the VRAM->VRAM copy. Pops destination-aligned pixel pairs
// from the copy FIFO and presents them to the VRAM write arbiter as masked
// 32-bit pair writes, walking the destination rectangle line by line.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; geometry latched on start
// ST_RUN   | popping pairs; one write held until acked
// ST_DRAIN | every pair popped, holding the final write until acked
module cv_copy_writer
  import gpu_cv_pkg::*;
#(
  parameter int X_W = VRAM_X_W,
  parameter int Y_W = VRAM_Y_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] dstX,
  input  logic [Y_W-1:0] dstY,
  input  logic [X_W:0]   width,
  input  logic [Y_W:0]   height,
  input  logic           forceMask,
  input  logic           fifoEmpty,
  input  logic [31:0]    fifoData,
  output logic           fifoPop,
  output logic           writeReq,
  output logic [X_W-2:0] writeAdrX,
  output logic [Y_W-1:0] writeAdrY,
  output logic [31:0]    writeData,
  output logic [1:0]     writeMask,
  input  logic           writeAck,
  output logic           busy,
  output logic           done
);

  localparam logic [X_W-2:0] X_ONE = (X_W-1)'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);
  localparam logic [X_W:0]   P_ONE = (X_W+1)'(1);
  localparam logic [Y_W:0]   L_ONE = (Y_W+1)'(1);

  cv_state_t      state;
  logic [X_W-2:0] start_x;
  logic [X_W-2:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic [X_W:0]   pairs_per_line;
  logic [X_W:0]   pair_cnt;
  logic [Y_W:0]   line_cnt;
  logic           xs_lo;
  logic           xe_lo;
  logic           force_mask;

  logic [X_W:0]   span_pix;
  logic [X_W:0]   ppl_calc;
  logic           is_first;
  logic           is_last;
  logic           last_pop;
  logic [1:0]     pair_mask;

  // pairs touched by a line: pixel span measured from the even pixel of the
  // first pair. Up to 513 pairs when an odd start spans the full 1024 pixels.
  always_comb begin
    span_pix = (X_W+1)'(dstX[0]) + width - P_ONE;
    ppl_calc = (span_pix >> 1) + P_ONE;
  end

  // position of the pair about to be popped within its line and the copy
  always_comb begin
    is_first = (pair_cnt == pairs_per_line);
    is_last  = (pair_cnt == P_ONE);
    last_pop = is_last && (line_cnt == L_ONE);
  end

  // pop only when the output slot is free or being freed this cycle
  assign fifoPop = (state == ST_RUN) && !fifoEmpty && (!writeReq || writeAck);

  cv_line_mask u_line_mask (
    .xs_lo    (xs_lo),
    .xe_lo    (xe_lo),
    .is_first (is_first),
    .is_last  (is_last),
    .mask     (pair_mask)
  );

  // sequencing FSM, rectangle walk counters and the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      start_x        <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      pairs_per_line <= '0;
      pair_cnt       <= '0;
      line_cnt       <= '0;
      xs_lo          <= 1'b0;
      xe_lo          <= 1'b0;
      force_mask     <= 1'b0;
      writeReq       <= 1'b0;
      writeAdrX      <= '0;
      writeAdrY      <= '0;
      writeData      <= '0;
      writeMask      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            start_x        <= dstX[X_W-1:1];
            cur_x          <= dstX[X_W-1:1];
            cur_y          <= dstY;
            pairs_per_line <= ppl_calc;
            pair_cnt       <= ppl_calc;
            line_cnt       <= height;
            xs_lo          <= dstX[0];
            // LSB of (dstX + width - 1) is the parity of the three terms
            xe_lo          <= dstX[0] ^ width[0] ^ 1'b1;
            force_mask     <= forceMask;
            busy           <= 1'b1;
            state          <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (fifoPop) begin
            writeReq  <= 1'b1;
            writeAdrX <= cur_x;
            writeAdrY <= cur_y;
            writeData <= force_mask ? (fifoData | FORCE_BITS) : fifoData;
            writeMask <= pair_mask;
            if (is_last) begin
              cur_x    <= start_x;
              cur_y    <= cur_y + Y_ONE;
              line_cnt <= line_cnt - L_ONE;
              pair_cnt <= pairs_per_line;
            end else begin
              cur_x    <= cur_x + X_ONE;
              pair_cnt <= pair_cnt - P_ONE;
            end
            if (last_pop) state <= ST_DRAIN;
          end else if (writeReq && writeAck) begin
            writeReq <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (writeReq && writeAck) begin
            writeReq <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          writeReq <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv_copy_writer.sv
// Scoreboard bench for the copy writer: each copy is expanded pixel by pixel
// into the expected sequence of pair writes, the FIFO contents are pushed
// alongside, and every accepted write is popped and compared.
module tb_cv_copy_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  dstX;
  logic [8:0]  dstY;
  logic [10:0] width;
  logic [9:0]  height;
  logic        forceMask;
  logic        fifoEmpty;
  logic [31:0] fifoData;
  logic        fifoPop;
  logic        writeReq;
  logic [8:0]  writeAdrX;
  logic [8:0]  writeAdrY;
  logic [31:0] writeData;
  logic [1:0]  writeMask;
  logic        writeAck;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [31:0] d;
    logic [1:0]  m;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  cv_copy_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dstX      (dstX),
    .dstY      (dstY),
    .width     (width),
    .height    (height),
    .forceMask (forceMask),
    .fifoEmpty (fifoEmpty),
    .fifoData  (fifoData),
    .fifoPop   (fifoPop),
    .writeReq  (writeReq),
    .writeAdrX (writeAdrX),
    .writeAdrY (writeAdrY),
    .writeData (writeData),
    .writeMask (writeMask),
    .writeAck  (writeAck),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expand the destination rectangle pixel by pixel into pair writes
  task automatic build_model(input int dx, input int dy, input int w, input int h,
                             input bit frc, input bit use_fixed, input logic [31:0] fixed);
    exp_t        cur;
    bit          have;
    logic [31:0] d;
    int          x;
    exp_q.delete();
    fifo_q.delete();
    for (int l = 0; l < h; l++) begin
      have = 1'b0;
      cur  = '0;
      for (int p = 0; p < w; p++) begin
        x = (dx + p) % 1024;
        if (!have || cur.x != 9'(x / 2)) begin
          if (have) exp_q.push_back(cur);
          cur.x = 9'(x / 2);
          cur.y = 9'((dy + l) % 512);
          cur.m = 2'b00;
          have  = 1'b1;
        end
        cur.m = cur.m | (((x % 2) == 1) ? 2'b10 : 2'b01);
      end
      exp_q.push_back(cur);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      d = use_fixed ? fixed : $urandom;
      fifo_q.push_back(d);
      exp_q[i].d = frc ? (d | 32'h8000_8000) : d;
    end
  endtask

  // run one copy; inputs driven and outputs sampled on the falling edge
  task automatic run_copy(input int dx, input int dy, input int w, input int h,
                          input bit frc, input int ack_delay, input bit gaps,
                          input bit stray, input int exp_done_k, input bit poke_start,
                          input int abort_k, input bit use_fixed, input logic [31:0] fixed);
    bit          fin = 1'b0;
    bit          pending = 1'b0;
    int          wait_cnt = 0;
    int          done_cnt = 0;
    logic [8:0]  sx, sy;
    logic [31:0] sd;
    logic [1:0]  sm;
    exp_t        e;
    build_model(dx, dy, w, h, frc, use_fixed, fixed);
    @(negedge clk);
    dstX = 10'(dx); dstY = 9'(dy); width = 11'(w); height = 10'(h);
    forceMask = frc; start = 1'b1; writeAck = 1'b0;
    fifoEmpty = 1'b1; fifoData = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      if (k == abort_k) begin
        rst = 1'b1; writeAck = 1'b0; fifoEmpty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_req", writeReq, 1'b0);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check_val("abort_no_done", done, 1'b0);
          check_val("abort_idle_req", writeReq, 1'b0);
        end
        exp_q.delete();
        fifo_q.delete();
        return;
      end
      if (pending) begin
        check_val("hold_req", writeReq, 1'b1);
        check_val("hold_adr_x", writeAdrX, sx);
        check_val("hold_adr_y", writeAdrY, sy);
        check_val("hold_data", writeData, sd);
        check_val("hold_mask", writeMask, sm);
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
        check_val("busy_at_done", busy, 1'b0);
        if (exp_done_k >= 0) check_val("done_cycle", k, exp_done_k);
      end
      if (poke_start && k == 3) begin
        start = 1'b1; dstX = 10'd100; dstY = 9'd50; width = 11'd7; height = 10'd5;
      end else begin
        start = 1'b0;
      end
      if (writeReq) begin
        if (wait_cnt >= ack_delay) begin
          writeAck = 1'b1; wait_cnt = 0;
        end else begin
          writeAck = 1'b0; wait_cnt++;
        end
      end else begin
        writeAck = stray ? 1'($urandom % 2) : 1'b0;
        wait_cnt = 0;
      end
      fifoEmpty = (fifo_q.size() == 0) || (gaps && ($urandom % 3 == 0));
      fifoData  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
      #1;
      check_val("no_pop_pending", fifoPop && writeReq && !writeAck, 1'b0);
      check_val("no_pop_empty", fifoPop && fifoEmpty, 1'b0);
      if (writeReq && writeAck) begin
        if (exp_q.size() == 0) begin
          check_val("extra_write", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_val("adr_x", writeAdrX, e.x);
          check_val("adr_y", writeAdrY, e.y);
          check_val("data", writeData, e.d);
          check_val("mask", writeMask, e.m);
        end
      end
      if (fifoPop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      pending = writeReq && !writeAck;
      sx = writeAdrX; sy = writeAdrY; sd = writeData; sm = writeMask;
      @(negedge clk);
    end
    writeAck = 1'b0; fifoEmpty = 1'b1; start = 1'b0;
    check_val("done_seen", fin, 1'b1);
    for (int j = 0; j < 2; j++) begin
      check_val("done_single", done, 1'b0);
      check_val("idle_req", writeReq, 1'b0);
      @(negedge clk);
    end
    check_val("done_count", done_cnt, 1);
    check_val("writes_left", exp_q.size(), 0);
    check_val("fifo_left", fifo_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dstX = '0; dstY = '0; width = 11'd1; height = 10'd1;
    forceMask = 1'b0; fifoEmpty = 1'b1; fifoData = '0; writeAck = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_req", writeReq, 1'b0);
    check_val("rst_pop", fifoPop, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_mask", writeMask, 2'b00);
    rst = 1'b0;

    //       dx    dy   w    h  frc dly gap str done poke abort fixed
    run_copy(0,    0,   4,   2, 0,  0,  0,  0,  5,   0,   -1,   0, 32'h0);
    run_copy(1,    10,  2,   1, 0,  0,  0,  0,  -1,  0,   -1,   0, 32'h0);
    run_copy(0,    20,  1,   1, 0,  0,  0,  0,  -1,  0,   -1,   0, 32'h0);
    run_copy(7,    21,  1,   1, 0,  0,  0,  0,  -1,  0,   -1,   0, 32'h0);
    run_copy(1023, 511, 2,   2, 0,  0,  0,  0,  -1,  0,   -1,   0, 32'h0);
    run_copy(5,    3,   9,   3, 0,  3,  1,  1,  -1,  1,   -1,   0, 32'h0);
    run_copy(2,    4,   3,   1, 1,  0,  0,  0,  -1,  0,   -1,   1, 32'h1234_0567);
    run_copy(1,    7,   1024,1, 0,  0,  1,  0,  -1,  0,   -1,   0, 32'h0);
    run_copy(3,    30,  8,   4, 0,  1,  0,  0,  -1,  0,   6,    0, 32'h0);
    run_copy(0,    0,   4,   2, 0,  0,  0,  0,  5,   0,   -1,   0, 32'h0);
    for (int r = 0; r < 3; r++) begin
      run_copy(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
               int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
               1'($urandom % 2), int'($urandom_range(0, 2)), 1'b1, 1'b1,
               -1, 1'b0, -1, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
